// File: rtl/audio_pkg.sv
// Shared audio types, default rates and the mixer saturation helper.
package audio_pkg;

    localparam int unsigned SAMPLE_W          = 16;
    localparam int unsigned DEFAULT_CLK_HZ    = 50_000_000;
    localparam int unsigned DEFAULT_SAMPLE_HZ = 44_100;
    // Widest accumulator any legal voice count needs (64 voices -> 16 + 6 bits).
    localparam int unsigned MAX_ACC_W         = SAMPLE_W + 6;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WAIT,
        COMMIT
    } sched_state_t;

    localparam logic signed [MAX_ACC_W-1:0] SAT_HI = 22'sd32767;
    localparam logic signed [MAX_ACC_W-1:0] SAT_LO = -22'sd32768;

    // Callers sign-extend their accumulator to MAX_ACC_W before calling.
    function automatic sample_t sat16(input logic signed [MAX_ACC_W-1:0] acc);
        if (acc > SAT_HI) begin
            return sample_t'(SAT_HI[SAMPLE_W-1:0]);
        end else if (acc < SAT_LO) begin
            return sample_t'(SAT_LO[SAMPLE_W-1:0]);
        end else begin
            return sample_t'(acc[SAMPLE_W-1:0]);
        end
    endfunction

endpackage

// File: rtl/sample_scheduler_if.sv
// Voice fetch port plus mixer output/status bundle of the sample scheduler.
interface sample_scheduler_if
    import audio_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 8
) ();

    localparam int unsigned VID_W = $clog2(NUM_VOICES);

    logic [NUM_VOICES-1:0] voice_active;
    logic                  voice_req;
    logic [VID_W-1:0]      voice_id;
    logic                  voice_ack;
    sample_t               voice_sample;
    sample_t               mixer_output;
    logic                  sample_valid;
    logic                  busy;
    logic                  underrun;
    logic                  clear_underrun;

    // Scheduler side.
    modport master (
        input  voice_active, voice_ack, voice_sample, clear_underrun,
        output voice_req, voice_id, mixer_output, sample_valid, busy, underrun
    );

    // Voice datapath / serializer side.
    modport slave (
        output voice_active, voice_ack, voice_sample, clear_underrun,
        input  voice_req, voice_id, mixer_output, sample_valid, busy, underrun
    );

endinterface

// File: rtl/sample_rate_tick.sv
// Phase-accumulator tick generator: exact average of SAMPLE_HZ ticks per CLK_HZ cycles.
module sample_rate_tick #(
    parameter int unsigned CLK_HZ    = audio_pkg::DEFAULT_CLK_HZ,
    parameter int unsigned SAMPLE_HZ = audio_pkg::DEFAULT_SAMPLE_HZ
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    // Wide enough to hold phase + SAMPLE_HZ before wrapping.
    localparam int unsigned PHASE_W = $clog2(CLK_HZ + SAMPLE_HZ);
    localparam logic [PHASE_W-1:0] STEP = PHASE_W'(SAMPLE_HZ);
    localparam logic [PHASE_W-1:0] WRAP = PHASE_W'(CLK_HZ);

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phaseNext;

    assign phaseNext = phase + STEP;
    assign tick      = (phaseNext >= WRAP);

    // Advance the phase, wrapping by CLK_HZ on the tick cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
        end else if (tick) begin
            phase <= phaseNext - WRAP;
        end else begin
            phase <= phaseNext;
        end
    end

endmodule

// File: rtl/sample_scheduler.sv
// Per-tick voice walker: fetches active voice samples, sums, saturates and commits.
module sample_scheduler
    import audio_pkg::*;
#(
    parameter int unsigned CLK_HZ     = audio_pkg::DEFAULT_CLK_HZ,
    parameter int unsigned SAMPLE_HZ  = audio_pkg::DEFAULT_SAMPLE_HZ,
    parameter int unsigned NUM_VOICES = 8
) (
    input logic                clk,
    input logic                reset,
    sample_scheduler_if.master bus
);

    localparam int unsigned VID_W = $clog2(NUM_VOICES);
    localparam int unsigned ACC_W = SAMPLE_W + VID_W;
    // One extra bit so idx can reach NUM_VOICES, the end-of-scan marker.
    localparam int unsigned IDX_W = VID_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES);

    logic                     tick;
    sched_state_t             state;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  sampleExt;
    logic signed [MAX_ACC_W-1:0] sumWide;
    logic                     voiceReq;
    logic [VID_W-1:0]         voiceId;
    sample_t                  mixerOut;
    logic                     sampleValid;
    logic                     underrunFlag;

    sample_rate_tick #(
        .CLK_HZ    (CLK_HZ),
        .SAMPLE_HZ (SAMPLE_HZ)
    ) tickGen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign sampleExt = ACC_W'(bus.voice_sample);
    assign sumWide   = MAX_ACC_W'(sum);

    assign bus.voice_req    = voiceReq;
    assign bus.voice_id     = voiceId;
    assign bus.mixer_output = mixerOut;
    assign bus.sample_valid = sampleValid;
    assign bus.busy         = (state != IDLE);
    assign bus.underrun     = underrunFlag;

    // Frame sequencer; all handshake and mixer outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            sum         <= '0;
            voiceReq    <= 1'b0;
            voiceId     <= '0;
            mixerOut    <= '0;
            sampleValid <= 1'b0;
        end else begin
            sampleValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        sum   <= '0;
                        idx   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (idx == LAST_IDX) begin
                        // Output and strobe land together in the COMMIT cycle.
                        mixerOut    <= sat16(sumWide);
                        sampleValid <= 1'b1;
                        state       <= COMMIT;
                    end else if (bus.voice_active[idx[VID_W-1:0]]) begin
                        voiceId  <= idx[VID_W-1:0];
                        voiceReq <= 1'b1;
                        state    <= WAIT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                WAIT: begin
                    // No timeout: a stalled voice stalls the frame.
                    if (bus.voice_ack) begin
                        sum      <= sum + sampleExt;
                        idx      <= idx + 1'b1;
                        voiceReq <= 1'b0;
                        state    <= SCAN;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky overrun flag; a new overrun beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrunFlag <= 1'b0;
        end else if (tick && (state != IDLE)) begin
            underrunFlag <= 1'b1;
        end else if (bus.clear_underrun) begin
            underrunFlag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed bench for sample_scheduler with a reference phase model for tick timing.
module tb_sample_scheduler;
    import audio_pkg::*;

    logic clk;
    logic reset;
    logic tickReset;
    logic smallTick;

    int errors = 0;
    int checks = 0;
    int lastExp = 0;
    sample_t vs [8];

    sample_scheduler_if #(.NUM_VOICES(8)) bus ();

    sample_scheduler #(
        .CLK_HZ     (50_000_000),
        .SAMPLE_HZ  (44_100),
        .NUM_VOICES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Scaled-down generator so a full cadence period fits in the run.
    sample_rate_tick #(
        .CLK_HZ    (5000),
        .SAMPLE_HZ (441)
    ) smallGen (
        .clk   (clk),
        .reset (tickReset),
        .tick  (smallTick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference phase accumulator tracking when the DUT should see a tick.
    int   modelPhase;
    logic modelTick;
    assign modelTick = (modelPhase + 44_100) >= 50_000_000;
    always @(posedge clk) begin
        if (reset) modelPhase <= 0;
        else if (modelTick) modelPhase <= modelPhase + 44_100 - 50_000_000;
        else modelPhase <= modelPhase + 44_100;
    end

    task automatic wait_tick(output bit ok);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (modelTick) begin
                ok = 1'b1;
                return;
            end
        end
        ok = 1'b0;
        checks++;
        errors++;
        $display("FAIL wait_tick: got no tick expected one within 2000 cycles");
    endtask

    task automatic wait_req(output bit ok);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.voice_req === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        ok = 1'b0;
        checks++;
        errors++;
        $display("FAIL wait_req: got voice_req=0 expected 1 within 20 cycles");
    endtask

    // Serve one frame: ack each request after ackDelay cycles with vs[id].
    task automatic run_frame(input logic [7:0] mask, input int ackDelay, input int expOut,
                             input string name);
        int lat, pulses, reqCycles, nextBit, seen;
        logic [2:0] heldId;
        logic [2:0] expId;
        bit ok;
        lat = 10 + $countones(mask) * ackDelay;
        bus.voice_active = mask;
        wait_tick(ok);
        if (!ok) return;
        pulses = 0; reqCycles = 0; nextBit = 0; seen = 0; heldId = '0;
        for (int k = 1; k <= lat + 3; k++) begin
            @(negedge clk);
            if (bus.voice_ack) bus.voice_ack = 1'b0;
            if (bus.voice_req) begin
                if (reqCycles == 0) begin
                    while (nextBit < 8 && !mask[nextBit]) nextBit++;
                    expId = 3'(nextBit);
                    checks++;
                    if (bus.voice_id !== expId) begin
                        errors++;
                        $display("FAIL %s voice_id: got %0d expected %0d", name, bus.voice_id, expId);
                    end
                    heldId = bus.voice_id;
                    nextBit++;
                    seen++;
                end else begin
                    checks++;
                    if (bus.voice_id !== heldId) begin
                        errors++;
                        $display("FAIL %s id_stable: got %0d expected %0d", name, bus.voice_id, heldId);
                    end
                end
                reqCycles++;
                if (reqCycles == ackDelay) begin
                    bus.voice_sample = vs[heldId];
                    bus.voice_ack = 1'b1;
                    reqCycles = 0;
                end
            end
            if (bus.sample_valid) begin
                pulses++;
                checks++;
                if (k != lat) begin
                    errors++;
                    $display("FAIL %s latency: got %0d expected %0d", name, k, lat);
                end
                checks++;
                if (bus.mixer_output !== 16'(expOut)) begin
                    errors++;
                    $display("FAIL %s mixer_output: got %0d expected %0d", name,
                             $signed(bus.mixer_output), expOut);
                end
            end
        end
        bus.voice_ack = 1'b0;
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL %s pulses: got %0d expected 1", name, pulses);
        end
        checks++;
        if (seen !== $countones(mask)) begin
            errors++;
            $display("FAIL %s voices: got %0d expected %0d", name, seen, $countones(mask));
        end
        lastExp = expOut;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.voice_active = '0;
        bus.voice_ack = 1'b0;
        bus.voice_sample = '0;
        bus.clear_underrun = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks += 6;
        if (bus.mixer_output !== 16'sd0) begin errors++; $display("FAIL reset mixer_output: got %0d expected 0", bus.mixer_output); end
        if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL reset sample_valid: got %b expected 0", bus.sample_valid); end
        if (bus.voice_req !== 1'b0) begin errors++; $display("FAIL reset voice_req: got %b expected 0", bus.voice_req); end
        if (bus.voice_id !== 3'd0) begin errors++; $display("FAIL reset voice_id: got %0d expected 0", bus.voice_id); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
        if (bus.underrun !== 1'b0) begin errors++; $display("FAIL reset underrun: got %b expected 0", bus.underrun); end
    endtask

    task automatic test_tick_cadence();
        int count, last, bad;
        tickReset = 1'b1;
        repeat (2) @(negedge clk);
        tickReset = 1'b0;
        count = 0; last = -1; bad = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (smallTick) begin
                count++;
                if (last >= 0 && !((c - last) == 11 || (c - last) == 12)) bad++;
                last = c;
            end
        end
        checks++;
        if (count !== 441) begin errors++; $display("FAIL cadence count: got %0d expected 441", count); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL cadence interval: got %0d bad expected 0", bad); end
    endtask

    // Empty mask with a stray ack held high: only the commit pulse, output zero.
    task automatic test_idle_frame();
        bit ok;
        bus.voice_active = 8'h00;
        bus.voice_sample = 16'sd1234;
        bus.voice_ack = 1'b1;
        wait_tick(ok);
        if (ok) begin
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                checks += 3;
                if (bus.sample_valid !== (k == 10)) begin errors++; $display("FAIL idle sample_valid@%0d: got %b expected %b", k, bus.sample_valid, (k == 10)); end
                if (bus.busy !== (k <= 10)) begin errors++; $display("FAIL idle busy@%0d: got %b expected %b", k, bus.busy, (k <= 10)); end
                if (bus.voice_req !== 1'b0) begin errors++; $display("FAIL idle voice_req@%0d: got %b expected 0", k, bus.voice_req); end
                if (k == 10) begin
                    checks++;
                    if (bus.mixer_output !== 16'sd0) begin errors++; $display("FAIL idle mixer_output: got %0d expected 0", $signed(bus.mixer_output)); end
                end
            end
        end
        bus.voice_ack = 1'b0;
        lastExp = 0;
    endtask

    task automatic test_mixing();
        vs[0] = 16'sd1000; vs[2] = -16'sd300;
        run_frame(8'h05, 3, 700, "mix05");
        vs[0] = 16'sd30000; vs[1] = 16'sd2767;
        run_frame(8'h03, 2, 32767, "exact_max");
        vs[0] = -16'sd5; vs[7] = 16'sd12345;
        run_frame(8'h81, 1, 12340, "mix81");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8; i++) vs[i] = 16'sd20000;
        run_frame(8'hFF, 1, 32767, "sat_pos");
        for (int i = 0; i < 8; i++) vs[i] = -16'sd20000;
        run_frame(8'hFF, 1, -32768, "sat_neg");
    endtask

    task automatic test_overrun();
        bit ok;
        int bad, pulses;
        bus.voice_active = 8'h01;
        wait_tick(ok);
        if (!ok) return;
        wait_req(ok);
        if (!ok) return;
        bad = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (bus.sample_valid !== 1'b0 || bus.voice_req !== 1'b1 || bus.voice_id !== 3'd0 ||
                bus.mixer_output !== 16'(lastExp)) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL overrun hold: got %0d bad cycles expected 0", bad); end
        checks++;
        if (bus.underrun !== 1'b1) begin errors++; $display("FAIL overrun flag: got %b expected 1", bus.underrun); end
        bus.voice_active = 8'h00;
        bus.voice_sample = 16'sd555;
        bus.voice_ack = 1'b1;
        @(negedge clk);
        bus.voice_ack = 1'b0;
        pulses = 0;
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (modelTick) begin ok = 1'b1; break; end
            if (bus.sample_valid) begin
                pulses++;
                checks++;
                if (bus.mixer_output !== 16'sd555) begin errors++; $display("FAIL overrun mixer_output: got %0d expected 555", $signed(bus.mixer_output)); end
            end
        end
        checks++;
        if (!ok || pulses !== 1) begin errors++; $display("FAIL overrun pulses: got %0d expected 1", pulses); end
        checks++;
        if (bus.underrun !== 1'b1) begin errors++; $display("FAIL overrun sticky: got %b expected 1", bus.underrun); end
        repeat (12) @(negedge clk);
        bus.clear_underrun = 1'b1;
        @(negedge clk);
        bus.clear_underrun = 1'b0;
        checks++;
        if (bus.underrun !== 1'b0) begin errors++; $display("FAIL overrun clear: got %b expected 0", bus.underrun); end
        lastExp = 0;
    endtask

    // Clear lands in the same cycle as a dropped tick: the set must win.
    task automatic test_clear_collision();
        bit ok;
        bus.voice_active = 8'h01;
        wait_tick(ok);
        if (!ok) return;
        wait_req(ok);
        if (!ok) return;
        checks++;
        if (bus.underrun !== 1'b0) begin errors++; $display("FAIL collide pre: got %b expected 0", bus.underrun); end
        wait_tick(ok);
        if (!ok) return;
        bus.clear_underrun = 1'b1;
        @(negedge clk);
        bus.clear_underrun = 1'b0;
        checks++;
        if (bus.underrun !== 1'b1) begin errors++; $display("FAIL collide set_wins: got %b expected 1", bus.underrun); end
        bus.voice_active = 8'h00;
        bus.voice_sample = 16'sd77;
        bus.voice_ack = 1'b1;
        @(negedge clk);
        bus.voice_ack = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.sample_valid) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || bus.mixer_output !== 16'sd77) begin errors++; $display("FAIL collide mixer_output: got %0d expected 77", $signed(bus.mixer_output)); end
        lastExp = 77;
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int bad;
        bus.voice_active = 8'h01;
        wait_tick(ok);
        if (!ok) return;
        wait_req(ok);
        if (!ok) return;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks += 5;
        if (bus.voice_req !== 1'b0) begin errors++; $display("FAIL rst_wait voice_req: got %b expected 0", bus.voice_req); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_wait busy: got %b expected 0", bus.busy); end
        if (bus.mixer_output !== 16'sd0) begin errors++; $display("FAIL rst_wait mixer_output: got %0d expected 0", $signed(bus.mixer_output)); end
        if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL rst_wait sample_valid: got %b expected 0", bus.sample_valid); end
        if (bus.underrun !== 1'b0) begin errors++; $display("FAIL rst_wait underrun: got %b expected 0", bus.underrun); end
        bad = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (bus.voice_req !== 1'b0 || bus.sample_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rst_wait quiet: got %0d active cycles expected 0", bad); end
        vs[0] = 16'sd42;
        run_frame(8'h01, 1, 42, "post_reset");
    endtask

    initial begin
        reset = 1'b1;
        tickReset = 1'b1;
        bus.voice_active = '0;
        bus.voice_ack = 1'b0;
        bus.voice_sample = '0;
        bus.clear_underrun = 1'b0;
        for (int i = 0; i < 8; i++) vs[i] = '0;
        test_reset();
        test_tick_cadence();
        test_idle_frame();
        test_mixing();
        test_saturation();
        test_overrun();
        test_clear_collision();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
